// File: rtl/counter_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : counter_cmd_sequencer
// Purpose  : Buffers counter commands in a FIFO and replays each rep+1 times
//            on the 4-slot counter's addr/control/immediate inputs.
// Options  : define SEQ_READBACK_EN to add res_valid/res_data slot readback.
// Revision : 1.0 - initial release
// ============================================================================
module counter_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_addr,
   input  logic                          cmd_dec,
   input  logic [3:0]                    cmd_imm,
   input  logic [3:0]                    cmd_rep,
   input  logic                          hold,
   output logic [1:0]                    cnt_addr,
   output logic                          cnt_control,
   output logic [3:0]                    cnt_immediate,
   input  logic [3:0]                    cnt_data,
   output logic                          busy,
   output logic                          done,
`ifdef SEQ_READBACK_EN
   output logic                          res_valid,
   output logic [3:0]                    res_data,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_EW = 11;
   localparam logic [c_AW:0] c_FULL = FIFO_DEPTH[c_AW:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   logic [c_EW-1:0] r_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_count;

   state_t     r_state;
   logic [1:0] r_addr;
   logic       r_ctrl;
   logic [3:0] r_imm_out;
   logic [3:0] r_imm;
   logic [3:0] r_rep_left;
   logic       r_done;

   state_t     w_state_nxt;
   logic [1:0] w_addr_nxt;
   logic       w_ctrl_nxt;
   logic [3:0] w_imm_out_nxt;
   logic [3:0] w_imm_nxt;
   logic [3:0] w_rep_nxt;
   logic       w_done_nxt;
   logic       w_pop;

   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic [c_EW-1:0] w_head;

   assign w_full    = (r_count == c_FULL);
   assign w_empty   = (r_count == '0);
   assign w_push    = cmd_valid & ~w_full;
   assign w_head    = r_mem[r_rd_ptr];

   assign cmd_ready     = ~w_full;
   assign fifo_count    = r_count;
   assign cnt_addr      = r_addr;
   assign cnt_control   = r_ctrl;
   assign cnt_immediate = r_imm_out;
   assign done          = r_done;
   assign busy          = (r_state != S_IDLE) | ~w_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {cmd_addr, cmd_dec, cmd_imm, cmd_rep};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_ctrl     <= 1'b0;
         r_imm_out  <= '0;
         r_imm      <= '0;
         r_rep_left <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_addr     <= w_addr_nxt;
         r_ctrl     <= w_ctrl_nxt;
         r_imm_out  <= w_imm_out_nxt;
         r_imm      <= w_imm_nxt;
         r_rep_left <= w_rep_nxt;
         r_done     <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_addr_nxt    = r_addr;
      w_ctrl_nxt    = r_ctrl;
      w_imm_out_nxt = r_imm_out;
      w_imm_nxt     = r_imm;
      w_rep_nxt     = r_rep_left;
      w_done_nxt    = 1'b0;
      w_pop         = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_imm_out_nxt = '0;
            if (!w_empty && !hold) begin
               w_pop         = 1'b1;
               w_addr_nxt    = w_head[10:9];
               w_ctrl_nxt    = w_head[8];
               w_imm_out_nxt = w_head[7:4];
               w_imm_nxt     = w_head[7:4];
               w_rep_nxt     = w_head[3:0];
               w_state_nxt   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // The application this cycle has happened even if hold is now
            // high, so it is always counted before pausing.
            if (r_rep_left == 4'd0) begin
               w_done_nxt = 1'b1;
               if (!hold && !w_empty) begin
                  w_pop         = 1'b1;
                  w_addr_nxt    = w_head[10:9];
                  w_ctrl_nxt    = w_head[8];
                  w_imm_out_nxt = w_head[7:4];
                  w_imm_nxt     = w_head[7:4];
                  w_rep_nxt     = w_head[3:0];
               end else begin
                  w_imm_out_nxt = '0;
                  w_state_nxt   = S_IDLE;
               end
            end else begin
               w_rep_nxt = r_rep_left - 4'd1;
               if (hold) begin
                  w_imm_out_nxt = '0;
                  w_state_nxt   = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!hold) begin
               w_imm_out_nxt = r_imm;
               w_state_nxt   = S_ISSUE;
            end
         end
         default: begin
            w_imm_out_nxt = '0;
            w_state_nxt   = S_IDLE;
         end
      endcase
   end

`ifdef SEQ_READBACK_EN
   logic       r_res_valid;
   logic [3:0] r_res_data;

   // Sampled on the completing edge, while cnt_addr still selects the slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         r_res_valid <= w_done_nxt;
         if (w_done_nxt) r_res_data <= cnt_data;
      end
   end

   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
`else
   logic w_unused_cnt_data;
   assign w_unused_cnt_data = ^cnt_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_cmd_sequencer
// Purpose  : Directed bench for counter_cmd_sequencer with a 4-slot counter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_addr = '0;
   logic       cmd_dec = 1'b0;
   logic [3:0] cmd_imm = '0;
   logic [3:0] cmd_rep = '0;
   logic       hold = 1'b0;
   logic [1:0] cnt_addr;
   logic       cnt_control;
   logic [3:0] cnt_immediate;
   logic [3:0] cnt_data;
   logic       busy;
   logic       done;
   logic [2:0] fifo_count;
`ifdef SEQ_READBACK_EN
   logic       res_valid;
   logic [3:0] res_data;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Downstream counter: writes slot[addr] +/- imm on every falling edge.
   logic [3:0] slot [4] = '{default: 4'd0};
   assign cnt_data = slot[cnt_addr];
   always @(negedge clk) begin
      slot[cnt_addr] <= cnt_control ? slot[cnt_addr] - cnt_immediate
                                    : slot[cnt_addr] + cnt_immediate;
   end

   always #5 clk = ~clk;

   counter_cmd_sequencer #(.FIFO_DEPTH(4)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_addr      (cmd_addr),
      .cmd_dec       (cmd_dec),
      .cmd_imm       (cmd_imm),
      .cmd_rep       (cmd_rep),
      .hold          (hold),
      .cnt_addr      (cnt_addr),
      .cnt_control   (cnt_control),
      .cnt_immediate (cnt_immediate),
      .cnt_data      (cnt_data),
      .busy          (busy),
      .done          (done),
`ifdef SEQ_READBACK_EN
      .res_valid     (res_valid),
      .res_data      (res_data),
`endif
      .fifo_count    (fifo_count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] a, input logic d, input logic [3:0] i, input logic [3:0] r);
      cmd_addr  = a;
      cmd_dec   = d;
      cmd_imm   = i;
      cmd_rep   = r;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic run(input int n, output int apps, output int dones, output int busys);
      apps = 0; dones = 0; busys = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (cnt_immediate != 4'd0) apps++;
         if (done) dones++;
         if (busy) busys++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1, "timeout");
   end

   initial begin
      int a, d, b;
      #2 rst = 1'b1;
      #1;
      check_val("rst_ready", cmd_ready, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_imm", cnt_immediate, 0);
      check_val("rst_addr", cnt_addr, 0);
      check_val("rst_ctrl", cnt_control, 0);
      check_val("rst_count", fifo_count, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // addr 2, inc 3, two applications
      push(2'd2, 1'b0, 4'd3, 4'd1);
      check_val("t1_count", fifo_count, 1);
      check_val("t1_imm_wait", cnt_immediate, 0);
      check_val("t1_busy_q", busy, 1);
      tick();
      check_val("t1_imm_a", cnt_immediate, 3);
      check_val("t1_addr", cnt_addr, 2);
      check_val("t1_ctrl", cnt_control, 0);
      tick();
      check_val("t1_imm_b", cnt_immediate, 3);
      check_val("t1_done_early", done, 0);
      tick();
      check_val("t1_done", done, 1);
      check_val("t1_imm_idle", cnt_immediate, 0);
      check_val("t1_busy_end", busy, 0);
      check_val("t1_slot2", slot[2], 6);
`ifdef SEQ_READBACK_EN
      check_val("t1_res_valid", res_valid, 1);
      check_val("t1_res_data", res_data, 6);
`endif
      tick();
      check_val("t1_done_once", done, 0);
      check_val("t1_addr_kept", cnt_addr, 2);

      // addr 1, dec 1 on zero slot wraps to 15
      push(2'd1, 1'b1, 4'd1, 4'd0);
      tick();
      check_val("t2_imm", cnt_immediate, 1);
      check_val("t2_ctrl", cnt_control, 1);
      check_val("t2_busy", busy, 1);
      tick();
      check_val("t2_done", done, 1);
      check_val("t2_busy_fall", busy, 0);
      check_val("t2_slot1", slot[1], 15);

      // fill FIFO under hold, then drain back-to-back
      hold = 1'b1;
      push(2'd1, 1'b0, 4'd1, 4'd0);
      push(2'd2, 1'b0, 4'd1, 4'd0);
      push(2'd1, 1'b0, 4'd2, 4'd0);
      check_val("t3_ready3", cmd_ready, 1);
      check_val("t3_count3", fifo_count, 3);
      push(2'd2, 1'b1, 4'd1, 4'd0);
      check_val("t3_ready_full", cmd_ready, 0);
      check_val("t3_count4", fifo_count, 4);
      check_val("t3_imm_hold", cnt_immediate, 0);
      push(2'd3, 1'b0, 4'd7, 4'd0);
      check_val("t3_count_rej", fifo_count, 4);
      check_val("t3_imm_hold2", cnt_immediate, 0);
      check_val("t3_busy", busy, 1);
      hold = 1'b0;
      run(4, a, d, b);
      check_val("t3_apps", a, 4);
      check_val("t3_dones_a", d, 3);
      run(3, a, d, b);
      check_val("t3_apps_tail", a, 0);
      check_val("t3_dones_b", d, 1);
      check_val("t3_slot1", slot[1], 2);
      check_val("t3_slot2", slot[2], 6);
      check_val("t3_slot3", slot[3], 0);
      check_val("t3_empty", fifo_count, 0);

      // addr 0, inc 2 x6 with a 3-cycle hold after the 2nd application
      push(2'd0, 1'b0, 4'd2, 4'd5);
      tick();
      check_val("t4_imm_a", cnt_immediate, 2);
      tick();
      check_val("t4_imm_b", cnt_immediate, 2);
      hold = 1'b1;
      tick();
      check_val("t4_hold_a", cnt_immediate, 0);
      check_val("t4_hold_busy", busy, 1);
      tick();
      check_val("t4_hold_b", cnt_immediate, 0);
      tick();
      check_val("t4_hold_c", cnt_immediate, 0);
      check_val("t4_hold_nodone", done, 0);
      hold = 1'b0;
      run(6, a, d, b);
      check_val("t4_apps_rest", a, 4);
      check_val("t4_dones", d, 1);
      check_val("t4_slot0", slot[0], 12);

      // reset in the middle of addr 3, inc 1 x8, with one command queued
      push(2'd3, 1'b0, 4'd1, 4'd7);
      push(2'd0, 1'b0, 4'd5, 4'd0);
      check_val("t5_count_pp", fifo_count, 1);
      check_val("t5_imm", cnt_immediate, 1);
      tick();
      tick();
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check_val("t5_imm_rst", cnt_immediate, 0);
      check_val("t5_count_rst", fifo_count, 0);
      check_val("t5_busy_rst", busy, 0);
      check_val("t5_ready_rst", cmd_ready, 1);
      check_val("t5_slot3", slot[3], 3);
      @(posedge clk);
      #1 rst = 1'b0;
      run(3, a, d, b);
      check_val("t5_apps_after", a, 0);
      check_val("t5_busy_after", b, 0);
      check_val("t5_slot3_kept", slot[3], 3);
      check_val("t5_slot0_kept", slot[0], 12);

      // imm 0 still runs three cycles and completes
      push(2'd2, 1'b0, 4'd0, 4'd2);
      run(5, a, d, b);
      check_val("t6_busy_cyc", b, 3);
      check_val("t6_dones", d, 1);
      check_val("t6_apps", a, 0);
      check_val("t6_slot2", slot[2], 6);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
